// File: rtl/inverter_seq_ctrl.sv
// Drives an alternating 0/1 pattern onto WIDTH inverter lanes, holds each for DWELL cycles,
// samples the lane outputs at the end of each dwell and accumulates mismatch statistics.
module inverter_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DWELL = 100,
    parameter int NPAT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] drive_a,
    input  logic [WIDTH-1:0] sense_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] err_mask
);

    localparam int              DW         = $clog2(DWELL + 1);
    localparam logic [DW-1:0]   LAST_DWELL = DW'(DWELL - 1);
    localparam logic [9:0]      LAST_PAT   = 10'(NPAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    dwell_cnt, dwell_n;
    logic [9:0]       pat, pat_n;
    logic [WIDTH-1:0] drive_n, mask_n, diff;
    logic [7:0]       cnt_n;
    logic             busy_n, done_n, pass_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dwell_cnt <= '0;
            pat       <= '0;
            drive_a   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_mask  <= '0;
        end else begin
            state     <= state_n;
            dwell_cnt <= dwell_n;
            pat       <= pat_n;
            drive_a   <= drive_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= cnt_n;
            err_mask  <= mask_n;
        end
    end

    // Outputs are computed for the coming cycle so every port comes straight from a flop.
    always_comb begin
        state_n = state;
        dwell_n = dwell_cnt;
        pat_n   = pat;
        drive_n = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        pass_n  = pass;
        cnt_n   = err_count;
        mask_n  = err_mask;
        diff    = sense_b ^ ~drive_a;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_DRIVE;
                    dwell_n = '0;
                    pat_n   = '0;
                    busy_n  = 1'b1;
                    pass_n  = 1'b0;
                    cnt_n   = '0;
                    mask_n  = '0;
                end
            end
            S_DRIVE: begin
                busy_n  = 1'b1;
                drive_n = drive_a;
                if (dwell_cnt == LAST_DWELL) begin
                    if (diff != '0) begin
                        mask_n = err_mask | diff;
                        if (err_count != 8'hFF) begin
                            cnt_n = err_count + 8'd1;
                        end
                    end
                    if (pat == LAST_PAT) begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        drive_n = '0;
                        pass_n  = (cnt_n == 8'd0);
                    end else begin
                        pat_n   = pat + 10'd1;
                        dwell_n = '0;
                        drive_n = {WIDTH{pat_n[0]}};
                    end
                end else begin
                    dwell_n = dwell_cnt + DW'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inverter_seq_ctrl.sv
// Directed bench: a cycle-offset model checks dut0 every cycle; literal checks pin key results.
module tb_inverter_seq_ctrl;

    localparam int D0 = 4;
    localparam int N0 = 4;
    localparam int D1 = 1;
    localparam int N1 = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] drive0, sense0, mask0, cnt0;
    logic [7:0] drive1, sense1, mask1, cnt1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    int         mode = 0;

    int checks = 0;
    int errors = 0;

    inverter_seq_ctrl #(.WIDTH(8), .DWELL(D0), .NPAT(N0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .drive_a(drive0), .sense_b(sense0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(cnt0), .err_mask(mask0)
    );

    inverter_seq_ctrl #(.WIDTH(8), .DWELL(D1), .NPAT(N1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .drive_a(drive1), .sense_b(sense1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(cnt1), .err_mask(mask1)
    );

    always #5 clk = ~clk;

    // Lane models: 0 ideal inverter, 1 lane 3 stuck at 0, 2 non-inverting buffer.
    always_comb begin
        case (mode)
            1:       sense0 = ~drive0 & 8'hF7;
            2:       sense0 = drive0;
            default: sense0 = ~drive0;
        endcase
    end
    assign sense1 = drive1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] pat_of(input int k);
        return ((((k - 1) / D0) % 2) == 1) ? 8'hFF : 8'h00;
    endfunction

    // Model: ph 0 idle, 1 running (k = cycles since accepting edge), 2 done cycle.
    int         m_ph = 0;
    int         m_k = 0;
    int         m_cnt = 0;
    logic [7:0] m_mask = 0;
    logic       m_pass = 0;
    bit         m_valid = 0;
    int         run_len = 0;
    int         last_len = 0;

    always @(negedge clk) begin
        logic [7:0] exp_drive;
        logic [7:0] diff;
        if (m_valid) begin
            exp_drive = (m_ph == 1) ? pat_of(m_k) : 8'h00;
            check("drive_a", 32'(drive0), 32'(exp_drive));
            check("busy", 32'(busy0), 32'(m_ph == 1));
            check("done", 32'(done0), 32'(m_ph == 2));
            check("pass", 32'(pass0), 32'(m_pass));
            check("err_count", 32'(cnt0), 32'(m_cnt));
            check("err_mask", 32'(mask0), 32'(m_mask));
        end
        if (busy0) run_len++;
        else begin
            if (done0) last_len = run_len;
            run_len = 0;
        end
        if (rst) begin
            m_valid = 1; m_ph = 0; m_cnt = 0; m_mask = 0; m_pass = 0;
        end else if (m_valid) begin
            case (m_ph)
                0: if (start0) begin
                    m_ph = 1; m_k = 1; m_cnt = 0; m_mask = 0; m_pass = 0;
                end
                1: begin
                    if (m_k % D0 == 0) begin
                        diff = sense0 ^ ~pat_of(m_k);
                        if (diff != 0) begin
                            m_mask |= diff;
                            if (m_cnt < 255) m_cnt++;
                        end
                    end
                    if (m_k == N0 * D0) begin
                        m_ph = 2;
                        m_pass = (m_cnt == 0);
                    end else m_k++;
                end
                default: m_ph = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1;
        end
        #1;
        if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int dn;
        int nb;
        bit seen;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_drive", 32'(drive0), 32'h00);
        check("rst_busy_done", 32'({busy0, done0, pass0}), 32'd0);
        check("rst_cnt_mask", 32'({cnt0, mask0}), 32'd0);

        mode = 0;
        tick(); pulse_start(); wait_done("ideal");
        check("ideal_busy_len", 32'(last_len), 32'd16);
        check("ideal_result", 32'({pass0, cnt0, mask0}), {15'd0, 1'b1, 8'd0, 8'h00});

        mode = 1;
        tick(); pulse_start(); wait_done("stuck");
        check("stuck_result", 32'({pass0, cnt0, mask0}), {15'd0, 1'b0, 8'd2, 8'h08});

        mode = 2;
        tick(); pulse_start(); wait_done("buffer");
        check("buffer_result", 32'({pass0, cnt0, mask0}), {15'd0, 1'b0, 8'd4, 8'hFF});

        // Abort on cycle 7: pattern 0 has already counted one buffer mismatch.
        tick(); pulse_start();
        for (int i = 0; i < 6; i++) tick();
        check("pre_abort_cnt", 32'(cnt0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", 32'({drive0, busy0, done0, pass0, cnt0, mask0}), 32'd0);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done0) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        mode = 0;
        tick(); pulse_start(); wait_done("after_abort");
        check("after_abort_pass", 32'({pass0, cnt0}), {23'd0, 1'b1, 8'd0});

        // Start held high: one idle cycle separates done from the next busy.
        tick();
        start0 = 1'b1;
        wait_done("held1");
        @(negedge clk);
        check("held_idle_gap", 32'(busy0), 32'd0);
        @(negedge clk);
        check("held_rerun", 32'(busy0), 32'd1);
        tick();
        start0 = 1'b0;
        wait_done("held2");
        check("held2_len", 32'(last_len), 32'd16);

        // A stray start mid-run changes nothing.
        mode = 1;
        tick(); tick(); pulse_start();
        for (int i = 0; i < 4; i++) tick();
        pulse_start();
        wait_done("midstart");
        check("midstart_len", 32'(last_len), 32'd16);
        check("midstart_result", 32'({pass0, cnt0, mask0}), {15'd0, 1'b0, 8'd2, 8'h08});
        tick(); tick(); tick();
        check("midstart_no_rerun", 32'(busy0), 32'd0);

        // Long buffer run: count saturates at 255.
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        nb = 0;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (busy1) nb++;
            if (done1) seen = 1;
        end
        check("sat_done_seen", 32'(seen), 32'd1);
        check("sat_busy_len", 32'(nb), 32'd300);
        check("sat_result", 32'({pass1, cnt1, mask1}), {15'd0, 1'b0, 8'd255, 8'hFF});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
